// File: rtl/sscell_rr_arbiter.sv
// Round-robin arbiter sharing one single-port sscell among NUM_REQ requesters,
// with bounded locked bursts and 1-cycle read response routing.
module sscell_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BW_INDEX = 16,
  parameter int BW_DATA  = 128,
  parameter int MAX_HOLD = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_list,
  output logic [NUM_REQ-1:0]            req_ready_list,
  input  logic [NUM_REQ-1:0]            req_wenable_list,
  input  logic [NUM_REQ-1:0]            req_lock_list,
  input  logic [BW_INDEX*NUM_REQ-1:0]   req_index_list,
  input  logic [BW_DATA/8*NUM_REQ-1:0]  req_wbyte_list,
  input  logic [BW_DATA*NUM_REQ-1:0]    req_wdata_list,
  output logic [NUM_REQ-1:0]            rsp_valid_list,
  output logic [BW_DATA-1:0]            rsp_rdata,
  output logic                          sscell_enable,
  output logic                          sscell_wenable,
  output logic                          sscell_renable,
  output logic [BW_INDEX-1:0]           sscell_index,
  output logic [BW_DATA/8-1:0]          sscell_wenable_byte,
  output logic [BW_DATA-1:0]            sscell_wdata,
  input  logic [BW_DATA-1:0]            sscell_rdata,
  input  logic                          sscell_stall
);
  localparam int BW_BYTE = BW_DATA / 8;
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW      = $clog2(MAX_HOLD + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  typedef struct packed {
    logic                wr;
    logic [BW_INDEX-1:0] index;
    logic [BW_BYTE-1:0]  wbyte;
    logic [BW_DATA-1:0]  wdata;
  } acc_t;

  logic [NUM_REQ-1:0][BW_INDEX-1:0] idx_arr;
  logic [NUM_REQ-1:0][BW_BYTE-1:0]  wbyte_arr;
  logic [NUM_REQ-1:0][BW_DATA-1:0]  wdata_arr;

  assign idx_arr   = req_index_list;
  assign wbyte_arr = req_wbyte_list;
  assign wdata_arr = req_wdata_list;

  state_t        state;
  logic [PW-1:0] ptr, owner, rsp_owner, winner;
  logic [HW-1:0] hold_cnt;
  logic          rsp_pending, win_found, grant, win_lock;
  acc_t          acc;

  // (a + k) mod NUM_REQ without relying on power-of-two wrap
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    if (state == LOCKED) begin
      winner    = owner;
      win_found = req_valid_list[owner];
    end else begin
      // Walk from the farthest offset back so the nearest valid one to ptr wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid_list[wrap_add(ptr, k)]) begin
          winner    = wrap_add(ptr, k);
          win_found = 1'b1;
        end
      end
    end
  end

  assign grant    = win_found & ~sscell_stall & ~rst;
  assign win_lock = req_lock_list[winner];

  always_comb begin
    acc.wr    = req_wenable_list[winner];
    acc.index = idx_arr[winner];
    acc.wbyte = req_wenable_list[winner] ? wbyte_arr[winner] : '0;
    acc.wdata = wdata_arr[winner];
  end

  assign req_ready_list      = grant ? (NUM_REQ'(1) << winner) : '0;
  assign sscell_enable       = grant;
  assign sscell_wenable      = grant & acc.wr;
  assign sscell_renable      = grant & ~acc.wr;
  assign sscell_index        = grant ? acc.index : '0;
  assign sscell_wenable_byte = grant ? acc.wbyte : '0;
  assign sscell_wdata        = grant ? acc.wdata : '0;

  assign rsp_valid_list = rsp_pending ? (NUM_REQ'(1) << rsp_owner) : '0;
  assign rsp_rdata      = sscell_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB;
      ptr         <= '0;
      owner       <= '0;
      hold_cnt    <= '0;
      rsp_pending <= 1'b0;
      rsp_owner   <= '0;
    end else begin
      rsp_pending <= grant & ~acc.wr;
      if (grant & ~acc.wr) rsp_owner <= winner;
      if (grant) begin
        case (state)
          ARB: begin
            if (win_lock && MAX_HOLD > 1) begin
              owner    <= winner;
              hold_cnt <= HW'(1);
              state    <= LOCKED;
            end else begin
              ptr <= wrap_add(winner, 1);
            end
          end
          LOCKED: begin
            if (win_lock && (int'(hold_cnt) + 1 < MAX_HOLD)) begin
              hold_cnt <= hold_cnt + 1'b1;
            end else begin
              // Hold limit or explicit release: rotate past the owner.
              ptr      <= wrap_add(owner, 1);
              hold_cnt <= '0;
              state    <= ARB;
            end
          end
          default: state <= ARB;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sscell_rr_arbiter.sv
// Scoreboard bench for sscell_rr_arbiter: directed grant expectations per cycle,
// expected read responses queued at grant time and compared one cycle later.
module tb_sscell_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = 16;
  localparam int DW = 128;
  localparam int BB = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]          t_vld, t_wen, t_lock;
  logic [N-1:0][IW-1:0]  t_idx;
  logic [N-1:0][BB-1:0]  t_wb;
  logic [N-1:0][DW-1:0]  t_wd;
  logic                  stall;

  logic [N-1:0]  req_ready_list, rsp_valid_list;
  logic [DW-1:0] rsp_rdata, sscell_wdata, sscell_rdata;
  logic          sscell_enable, sscell_wenable, sscell_renable;
  logic [IW-1:0] sscell_index;
  logic [BB-1:0] sscell_wenable_byte;

  sscell_rr_arbiter #(.NUM_REQ(N), .BW_INDEX(IW), .BW_DATA(DW), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_list(t_vld), .req_ready_list(req_ready_list),
    .req_wenable_list(t_wen), .req_lock_list(t_lock),
    .req_index_list(t_idx), .req_wbyte_list(t_wb), .req_wdata_list(t_wd),
    .rsp_valid_list(rsp_valid_list), .rsp_rdata(rsp_rdata),
    .sscell_enable(sscell_enable), .sscell_wenable(sscell_wenable),
    .sscell_renable(sscell_renable), .sscell_index(sscell_index),
    .sscell_wenable_byte(sscell_wenable_byte), .sscell_wdata(sscell_wdata),
    .sscell_rdata(sscell_rdata), .sscell_stall(stall)
  );

  function automatic logic [DW-1:0] init_word(input int idx);
    logic [15:0] i16;
    i16 = 16'(idx);
    return {8{i16}} ^ {4{32'hDEADBEEF}};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [BB-1:0] wb,
                                          input logic [DW-1:0] wd);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BB; b++) if (wb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Cell model: 1-cycle synchronous read, byte-masked write.
  logic [DW-1:0] cell_mem [int];
  initial sscell_rdata = '0;
  always @(posedge clk) begin
    if (sscell_enable) begin
      if (sscell_wenable)
        cell_mem[int'(sscell_index)] = merge(cell_mem.exists(int'(sscell_index)) ?
          cell_mem[int'(sscell_index)] : init_word(int'(sscell_index)), sscell_wenable_byte, sscell_wdata);
      else
        sscell_rdata <= cell_mem.exists(int'(sscell_index)) ?
          cell_mem[int'(sscell_index)] : init_word(int'(sscell_index));
    end
  end

  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          q[$];
  logic [DW-1:0] exp_mem [int];
  int            n_chk = 0;
  int            n_err = 0;

  function automatic logic [DW-1:0] exp_rd(input int idx);
    return exp_mem.exists(idx) ? exp_mem[idx] : init_word(idx);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr_in();
    t_vld = '0; t_wen = '0; t_lock = '0; t_idx = '0; t_wb = '0; t_wd = '0;
  endtask

  task automatic q_reset();
    rsp_t z;
    z.vld = '0; z.data = '0;
    q.delete();
    q.push_back(z);
  endtask

  // Called right after inputs are driven; g = expected winner, -1 for no grant.
  task automatic step(input int g, input string tag);
    rsp_t e, n;
    logic [N-1:0] oh;
    #1;
    e = q.pop_front();
    chk({tag, ":rsp_vld"}, DW'(rsp_valid_list), DW'(e.vld));
    if (e.vld != 0) chk({tag, ":rsp_data"}, rsp_rdata, e.data);
    oh = (g >= 0) ? N'(1 << g) : '0;
    chk({tag, ":ready"}, DW'(req_ready_list), DW'(oh));
    chk({tag, ":enable"}, DW'(sscell_enable), DW'(g >= 0));
    n.vld = '0; n.data = '0;
    if (g >= 0) begin
      chk({tag, ":wen"}, DW'(sscell_wenable), DW'(t_wen[g]));
      chk({tag, ":ren"}, DW'(sscell_renable), DW'(!t_wen[g]));
      chk({tag, ":index"}, DW'(sscell_index), DW'(t_idx[g]));
      chk({tag, ":wbyte"}, DW'(sscell_wenable_byte), t_wen[g] ? DW'(t_wb[g]) : '0);
      if (t_wen[g]) begin
        chk({tag, ":wdata"}, sscell_wdata, t_wd[g]);
        exp_mem[int'(t_idx[g])] = merge(exp_rd(int'(t_idx[g])), t_wb[g], t_wd[g]);
      end else begin
        n.vld  = oh;
        n.data = exp_rd(int'(t_idx[g]));
      end
    end
    q.push_back(n);
  endtask

  initial begin
    clr_in();
    stall = 1'b0;
    q_reset();

    // Reset holds everything off even with a valid request present
    @(negedge clk); t_vld = 4'b0001; step(-1, "rst_hold");
    @(negedge clk); rst = 1'b0; clr_in(); step(-1, "idle0");

    // Continuous reads from all four: 0,1,2,3,0,...
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      t_vld = 4'hF; t_wen = '0;
      for (int i = 0; i < N; i++) t_idx[i] = 16'(i * 8 + c);
      step(c % 4, "rr");
    end
    @(negedge clk); clr_in(); step(-1, "rr_drain");

    // Partial write then readback from req1
    @(negedge clk);
    t_vld = 4'b0010; t_wen = 4'b0010; t_idx[1] = 16'd5;
    t_wb[1] = 16'h00FF; t_wd[1] = {16{8'hA5}};
    step(1, "wr");
    @(negedge clk); t_wen = '0; step(1, "rd");
    @(negedge clk); clr_in(); step(-1, "rd_drain");

    // Locked burst from req2 capped at 8, req0 competing
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      clr_in();
      t_vld[0] = 1'b1; t_idx[0] = 16'(200 + c);
      t_vld[2] = (c <= 12); t_lock[2] = (c < 12); t_idx[2] = 16'(300 + c);
      step((c == 8 || c == 13) ? 0 : 2, "lock");
    end
    @(negedge clk); clr_in(); step(-1, "lock_drain");

    // Stall right after a read from req0: response still delivered
    @(negedge clk); t_vld = 4'b0001; t_idx[0] = 16'd40; step(0, "st_acc");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); stall = 1'b1; t_vld = 4'b0011; t_idx[1] = 16'd41; step(-1, "stall");
    end
    @(negedge clk); stall = 1'b0; step(1, "st_resume");
    @(negedge clk); clr_in(); step(-1, "st_drain");

    // Locked owner bubbles: no grant to others until it releases
    @(negedge clk); t_vld = 4'b1000; t_lock = 4'b1000; t_idx[3] = 16'd60; step(3, "bub_lock");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); t_vld = 4'b0010; t_idx[1] = 16'd61; step(-1, "bubble");
    end
    @(negedge clk); t_vld = 4'b1010; t_lock = '0; step(3, "bub_rel");
    @(negedge clk); t_vld = 4'b0010; step(1, "bub_next");
    @(negedge clk); clr_in(); step(-1, "bub_drain");

    // Async reset while locked with a read pending
    @(negedge clk); t_vld = 4'b0001; t_lock = 4'b0001; t_idx[0] = 16'd70; step(0, "rl_lock");
    @(negedge clk); rst = 1'b1; q_reset(); step(-1, "rst_mid");
    @(negedge clk); rst = 1'b0; clr_in(); t_vld = 4'b1000; t_idx[3] = 16'd71; step(3, "post_rst");
    @(negedge clk); clr_in(); step(-1, "post_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
